// File: rtl/mem_master_ctrl.sv
// -----------------------------------------------------------------------------
// mem_master_ctrl
//   Initiator for a 2**AW x DW synchronous program RAM (Clock, In, D, Address,
//   WE, Q). Takes single writes and 1..2**AW-beat read bursts on a valid/ready
//   request port and returns read beats on a valid/ready response port.
//   All RAM-facing signals come straight from flops. The RAM init strobe
//   (mem_in_o, active low) is held low through reset, so every reset of this
//   block also reloads the RAM image.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   req_valid_i   request present
//   req_ready_o   request can be taken (IDLE only)
//   req_we_i      1 = single write, 0 = read burst
//   req_addr_i    start address
//   req_wdata_i   write data (writes only)
//   req_len_i     read beats minus one (reads only)
//   rsp_valid_o   read beat on rsp_data_o
//   rsp_ready_i   consumer takes the beat
//   rsp_data_o    read beat, stable while stalled
//   wr_done_o     one-cycle pulse once a write has been committed
//   mem_in_o      RAM init strobe, active low
//   mem_we_o      RAM write enable
//   mem_addr_o    RAM address
//   mem_d_o       RAM write data
//   mem_q_i       RAM registered read data
// -----------------------------------------------------------------------------
module mem_master_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [AW-1:0] req_len_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic          wr_done_o,
  output logic          mem_in_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_d_o,
  input  logic [DW-1:0] mem_q_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          we_q, we_d;
  logic          in_q, in_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          wr_done_q, wr_done_d;
  logic [AW-1:0] beats_q, beats_d;

  logic accept;
  assign accept = req_valid_i && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdat_q      <= '0;
      we_q        <= 1'b0;
      // Init strobe low for the whole reset; released on the first clean edge.
      in_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_done_q   <= 1'b0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      we_q        <= we_d;
      in_q        <= in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_done_q   <= wr_done_d;
      beats_q     <= beats_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    // WE and wr_done are single-cycle strobes: they default low every cycle,
    // so nothing but an accepted write can ever raise WE.
    we_d        = 1'b0;
    in_d        = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    wr_done_d   = 1'b0;
    beats_d     = beats_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr_i;
          if (req_we_i) begin
            wdat_d  = req_wdata_i;
            we_d    = 1'b1;
            state_d = WR;
          end else begin
            beats_d = req_len_i;
            state_d = RD_ADDR;
          end
        end
      end

      // RAM commits at the edge closing this cycle.
      WR: begin
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end

      // RAM registers Q from the stable address at the closing edge.
      RD_ADDR: state_d = RD_WAIT;

      // Q is now valid; capture it into the response holding register.
      RD_WAIT: begin
        rsp_data_d  = mem_q_i;
        rsp_valid_d = 1'b1;
        state_d     = RD_RESP;
      end

      RD_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (beats_q == '0) begin
            state_d = IDLE;
          end else begin
            beats_d = beats_q - AW'(1);
            // Wraps silently at the top of the RAM.
            addr_d  = addr_q + AW'(1);
            state_d = RD_ADDR;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign wr_done_o   = wr_done_q;
  assign mem_in_o    = in_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_d_o     = wdat_q;

endmodule

// File: tb/tb_mem_master_ctrl.sv
module tb_mem_master_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [AW-1:0] req_len = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, wr_done, mem_in, mem_we;
  logic [DW-1:0] rsp_data, mem_d;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_q;

  // Environment RAM and the reference view of its contents.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] mdl [N];

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;

  always #5 clk = ~clk;

  mem_master_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .wr_done_o(wr_done),
    .mem_in_o(mem_in), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_d_o(mem_d), .mem_q_i(mem_q)
  );

  // Init image: addr 1 = 3E, addr 5 = 7F, others a fixed pattern.
  function automatic logic [DW-1:0] img(input int a);
    case (a)
      1:       return 8'h3E;
      5:       return 8'h7F;
      default: return 8'((a * 37 + 11) & 8'hFF);
    endcase
  endfunction

  // Program RAM: init strobe reloads, WE writes, otherwise registered read.
  always @(posedge clk) begin
    if (mem_in === 1'b0) begin
      for (int i = 0; i < N; i++) ram[i] <= img(i);
    end else if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_d;
    end else begin
      mem_q <= ram[mem_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; leaves the bench at the negedge after the first clean edge.
  task automatic do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_in", 32'(mem_in), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_d", 32'(mem_d), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_wr_done", 32'(wr_done), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mem_in_release", 32'(mem_in), 1);
    for (int i = 0; i < N; i++) mdl[i] = img(i);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(req_ready), 1);
  endtask

  // Entered at the negedge following the write accept edge.
  task automatic write_tail(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_d", 32'(mem_d), 32'(d));
    chk("wr_done_early", 32'(wr_done), 0);
    chk("wr_busy", 32'(req_ready), 0);
    @(negedge clk);
    chk("wr_we_off", 32'(mem_we), 0);
    chk("wr_done", 32'(wr_done), 1);
    mdl[a] = d;
    @(negedge clk);
    chk("wr_done_pulse", 32'(wr_done), 0);
    chk("wr_ready_back", 32'(req_ready), 1);
  endtask

  task automatic do_write(input int a, input int d);
    wait_idle();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
    req_len   = AW'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    write_tail(AW'(a), DW'(d));
  endtask

  // Read burst; every beat is compared with the model. With hold set, a
  // conflicting write request stays asserted for the whole burst.
  task automatic do_read(input int addr, input int len, input int stall0,
                         input bit rnd, input bit hold);
    int n;
    int st;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    wait_idle();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(addr);
    req_len   = AW'(len);
    req_wdata = DW'($urandom);
    @(negedge clk);
    if (hold) begin
      req_we    = 1'b1;
      req_addr  = hold_addr;
      req_wdata = hold_data;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i <= len; i++) begin
      a   = AW'(addr + i);
      exp = mdl[a];
      chk("rsp_valid_lo", 32'(rsp_valid), 0);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
        chk("rd_busy", 32'(req_ready), 0);
        chk("rd_no_we", 32'(mem_we), 0);
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      chk("beat_latency", 32'(n), 2);
      chk("rsp_data", 32'(rsp_data), 32'(exp));
      chk("beat_addr", 32'(mem_addr), 32'(a));
      st = rnd ? int'($urandom_range(0, 3)) : ((i == 0) ? stall0 : 0);
      rsp_ready = 1'b0;
      repeat (st) begin
        @(negedge clk);
        chk("stall_valid", 32'(rsp_valid), 1);
        chk("stall_data", 32'(rsp_data), 32'(exp));
        chk("stall_addr", 32'(mem_addr), 32'(a));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    chk("rsp_valid_end", 32'(rsp_valid), 0);
    chk("rd_ready_back", 32'(req_ready), 1);
  endtask

  initial begin
    int r;
    int len;
    @(negedge clk);

    // 1: reset, then image read of addr 1.
    do_reset();
    do_read(1, 0, 0, 1'b0, 1'b0);
    chk("img_addr1", 32'(mdl[1]), 32'h3E);

    // 2: write then read back.
    do_write(5, 8'hA5);
    do_read(5, 0, 0, 1'b0, 1'b0);

    // 3: wrapping burst across the top of the RAM.
    do_write(30, 8'h11);
    do_write(31, 8'h12);
    do_write(0, 8'h13);
    do_write(1, 8'h14);
    do_read(30, 3, 0, 1'b0, 1'b0);

    // 4: first beat stalled 5 cycles, 3 beats total.
    do_read(3, 2, 5, 1'b0, 1'b0);

    // Full 32-beat sweep from address 0.
    do_read(0, 31, 0, 1'b0, 1'b0);

    // 5: reset during RD_WAIT of a 4-beat burst.
    wait_idle();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(0);
    req_len   = AW'(3);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (4) begin
      chk("abort_valid", 32'(rsp_valid), 0);
      chk("abort_ready", 32'(req_ready), 1);
      @(negedge clk);
    end
    do_read(5, 0, 0, 1'b0, 1'b0);
    chk("img_addr5", 32'(mdl[5]), 32'h7F);

    // 6: conflicting request held through a burst, taken once afterwards.
    hold_addr = AW'(9);
    hold_data = 8'hC3;
    do_read(8, 3, 1, 1'b0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    write_tail(hold_addr, hold_data);
    repeat (4) begin
      chk("once_we", 32'(mem_we), 0);
      chk("once_done", 32'(wr_done), 0);
      @(negedge clk);
    end
    do_read(9, 0, 0, 1'b0, 1'b0);

    // Randomized mix against the model.
    repeat (40) begin
      r = int'($urandom_range(0, 2));
      if (r == 0) begin
        do_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      end else begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1))
                                          : int'($urandom_range(0, 3));
        do_read(int'($urandom_range(0, N - 1)), len, 0, 1'b1, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
